// File: rtl/apb_master_fsm_if.sv
// apb_master_fsm_if -- command/response port plus APB bus for apb_master_fsm.
//   req_*  : valid/ready command port (write flag, byte address, write data)
//   rsp_*  : one-cycle response pulse (decode error flag, read data)
//   APB    : pselx (one-hot), penable, pwrite, paddr, pwdata, prdata
//            pready is present only when APB_PREADY_EN is defined.
// Modports: master = the FSM's view, slave = the opposite end (agent/bench).
interface apb_master_fsm_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic [NSLV-1:0]   pselx;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
`ifdef APB_PREADY_EN
  logic              pready;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
           pselx, penable, pwrite, paddr, pwdata
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
           pselx, penable, pwrite, paddr, pwdata
  );
`else
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
           pselx, penable, pwrite, paddr, pwdata
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
           pselx, penable, pwrite, paddr, pwdata
  );
`endif
endinterface

// File: rtl/apb_master_fsm.sv
// apb_master_fsm -- APB initiator with 4-way address decode.
// Turns valid/ready commands into APB SETUP/ACCESS sequences and returns a
// one-cycle response pulse (read data or decode error).
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : asynchronous active-high reset
//   bus  : apb_master_fsm_if.master (command, response and APB signals)
// Decode: addr[31:28]==4'h8 selects slave addr[27:26]; anything else errors.
// Optional: `define APB_PREADY_EN adds pready wait states in ACCESS.
module apb_master_fsm #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = 4
) (
  input  logic              clk,
  input  logic              rst,
  apb_master_fsm_if.master  bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t          state;
  logic            done;
  logic            accept;
  logic            dec_ok;
  logic            load;
  logic            err_pend;
  logic [NSLV-1:0] dec_sel;

  always_comb begin
    dec_sel = '0;
    dec_ok  = (bus.req_addr[ADDR_W-1 -: 4] == 4'h8);
    if (dec_ok) dec_sel[bus.req_addr[ADDR_W-5 -: 2]] = 1'b1;
  end

`ifdef APB_PREADY_EN
  assign done = bus.pready;
`else
  assign done = 1'b1;
`endif

  assign bus.req_ready = (state == IDLE) || ((state == ACCESS) && done);
  assign accept        = bus.req_valid && bus.req_ready;
  assign load          = accept && dec_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      err_pend      <= 1'b0;
      bus.pselx     <= '0;
      bus.penable   <= 1'b0;
      bus.pwrite    <= 1'b0;
      bus.paddr     <= '0;
      bus.pwdata    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
      case (state)
        IDLE: begin
          // An error request accepted at the end of ACCESS is answered here,
          // one cycle after the completing transfer's pulse. If another error
          // arrives in this same cycle it is deferred by one more cycle.
          bus.rsp_valid <= err_pend || (accept && !dec_ok);
          bus.rsp_err   <= err_pend || (accept && !dec_ok);
          err_pend      <= err_pend && accept && !dec_ok;
          if (load) state <= SETUP;
        end
        SETUP: begin
          state       <= ACCESS;
          bus.penable <= 1'b1;
        end
        ACCESS: begin
          if (done) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= bus.pwrite ? '0 : bus.prdata;
            bus.penable   <= 1'b0;
            if (load) begin
              state <= SETUP;
            end else begin
              state     <= IDLE;
              bus.pselx <= '0;
              err_pend  <= accept;   // accepted but not decoded
            end
          end
        end
        default: state <= IDLE;
      endcase
      // Address phase fields; pwdata only moves on writes.
      if (load) begin
        bus.pselx  <= dec_sel;
        bus.paddr  <= bus.req_addr;
        bus.pwrite <= bus.req_write;
        if (bus.req_write) bus.pwdata <= bus.req_wdata;
      end
    end
  end

endmodule
